// File: rtl/bcd_counter4_if.sv
// Handshake bundle for the four-digit BCD counter: control/load inputs
// travel from the master, digit/tick/wrap outputs come back from the slave.
interface bcd_counter4_if;
    logic        run;
    logic        up;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic [3:0]  digit0;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;
    logic        tick;
    logic        wrap;

    modport master (
        output run, up, clear, load, load_val,
        input  digit0, digit1, digit2, digit3, tick, wrap
    );

    modport slave (
        input  run, up, clear, load, load_val,
        output digit0, digit1, digit2, digit3, tick, wrap
    );
endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with prescaler. Digits are always legal
// BCD (loads above 9 clamp to 9); carry/borrow ripples in one cycle.
module bcd_counter4 #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic           clk,
    input  logic           reset,
    bcd_counter4_if.slave  bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [3:0][3:0] cnt_q, cnt_d;
    logic [PW-1:0]   p_q, p_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;

    logic            step;
    logic [3:0][3:0] bump;
    logic            carry;

    // Next count for a step (up or down) plus carry-out, and priority-ordered next state
    always_comb begin
        step  = bus.run && (p_q == P_LAST);
        bump  = cnt_q;
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (bus.up) begin
                    if (bump[i] == 4'd9) begin
                        bump[i] = 4'd0;
                    end else begin
                        bump[i] = bump[i] + 4'd1;
                        carry   = 1'b0;
                    end
                end else begin
                    if (bump[i] == 4'd0) begin
                        bump[i] = 4'd9;
                    end else begin
                        bump[i] = bump[i] - 4'd1;
                        carry   = 1'b0;
                    end
                end
            end
        end

        cnt_d  = cnt_q;
        p_d    = p_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (bus.clear) begin
            cnt_d = '0;
            p_d   = '0;
        end else if (bus.load) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_d[i] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*i +: 4];
            end
            p_d = '0;
        end else if (step) begin
            cnt_d  = bump;
            p_d    = '0;
            tick_d = 1'b1;
            wrap_d = carry;
        end else if (bus.run) begin
            p_d = p_q + 1'b1;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            p_q    <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            p_q    <= p_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.digit0 = cnt_q[0];
    assign bus.digit1 = cnt_q[1];
    assign bus.digit2 = cnt_q[2];
    assign bus.digit3 = cnt_q[3];
    assign bus.tick   = tick_q;
    assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_counter4.sv
// Directed bench for bcd_counter4 with three prescaler settings (4, 1, 3).
module tb_bcd_counter4;

    logic clk = 1'b0;
    logic rst4 = 1'b1;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    bcd_counter4_if i4 ();
    bcd_counter4_if i1 ();
    bcd_counter4_if i3 ();

    bcd_counter4 #(.TICK_DIV(4)) u_dut4 (.clk(clk), .reset(rst4), .bus(i4));
    bcd_counter4 #(.TICK_DIV(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(i1));
    bcd_counter4 #(.TICK_DIV(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(i3));

    logic [15:0] cnt4, cnt1, cnt3;
    assign cnt4 = {i4.digit3, i4.digit2, i4.digit1, i4.digit0};
    assign cnt1 = {i1.digit3, i1.digit2, i1.digit1, i1.digit0};
    assign cnt3 = {i3.digit3, i3.digit2, i3.digit1, i3.digit0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; returns on the following falling edge.
    task automatic edge1();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i4.run = 1'b0; i4.up = 1'b1; i4.clear = 1'b0; i4.load = 1'b0; i4.load_val = '0;
        i1.run = 1'b0; i1.up = 1'b1; i1.clear = 1'b0; i1.load = 1'b0; i1.load_val = '0;
        i3.run = 1'b0; i3.up = 1'b1; i3.clear = 1'b0; i3.load = 1'b0; i3.load_val = '0;

        // Reset and count, TICK_DIV=4
        i4.run = 1'b1;
        edge1();
        check_eq("reset_digits4", {16'h0, cnt4}, 32'h0000);
        check_eq("reset_tick4", {31'h0, i4.tick}, 32'h0);
        edge1();
        check_eq("reset_hold4", {16'h0, cnt4}, 32'h0000);
        rst4 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            edge1();
            check_eq($sformatf("tick4_e%0d", k), {31'h0, i4.tick}, (k % 4 == 0) ? 32'h1 : 32'h0);
            if (k == 3) check_eq("cnt4_e3", {16'h0, cnt4}, 32'h0000);
            if (k == 4) check_eq("cnt4_e4", {16'h0, cnt4}, 32'h0001);
            if (k == 8) check_eq("cnt4_e8", {16'h0, cnt4}, 32'h0002);
        end

        // Pause: 2 edges running, 10 idle, resume
        edge1();
        edge1();
        i4.run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            edge1();
            check_eq("pause_cnt", {16'h0, cnt4}, 32'h0002);
            check_eq("pause_tick", {31'h0, i4.tick}, 32'h0);
        end
        i4.run = 1'b1;
        edge1();
        check_eq("resume_e1_tick", {31'h0, i4.tick}, 32'h0);
        check_eq("resume_e1_cnt", {16'h0, cnt4}, 32'h0002);
        edge1();
        check_eq("resume_e2_tick", {31'h0, i4.tick}, 32'h1);
        check_eq("resume_e2_cnt", {16'h0, cnt4}, 32'h0003);
        i4.run = 1'b0;

        // Decade carry, TICK_DIV=1
        i1.load = 1'b1; i1.load_val = 16'h0999;
        edge1();
        check_eq("load_0999", {16'h0, cnt1}, 32'h0999);
        check_eq("load_0999_tick", {31'h0, i1.tick}, 32'h0);
        i1.load = 1'b0; i1.run = 1'b1; i1.up = 1'b1;
        edge1();
        check_eq("carry_cnt", {16'h0, cnt1}, 32'h1000);
        check_eq("carry_tick", {31'h0, i1.tick}, 32'h1);
        check_eq("carry_wrap", {31'h0, i1.wrap}, 32'h0);
        i1.run = 1'b0;

        // Wrap up
        i1.load = 1'b1; i1.load_val = 16'h9999;
        edge1();
        i1.load = 1'b0; i1.run = 1'b1; i1.up = 1'b1;
        edge1();
        check_eq("wrapup_cnt", {16'h0, cnt1}, 32'h0000);
        check_eq("wrapup_tick", {31'h0, i1.tick}, 32'h1);
        check_eq("wrapup_wrap", {31'h0, i1.wrap}, 32'h1);
        i1.run = 1'b0;
        edge1();
        check_eq("idle_tick", {31'h0, i1.tick}, 32'h0);
        check_eq("idle_wrap", {31'h0, i1.wrap}, 32'h0);

        // Wrap down
        i1.load = 1'b1; i1.load_val = 16'h0000;
        edge1();
        i1.load = 1'b0; i1.run = 1'b1; i1.up = 1'b0;
        edge1();
        check_eq("wrapdn_cnt", {16'h0, cnt1}, 32'h9999);
        check_eq("wrapdn_tick", {31'h0, i1.tick}, 32'h1);
        check_eq("wrapdn_wrap", {31'h0, i1.wrap}, 32'h1);
        edge1();
        check_eq("down_cnt", {16'h0, cnt1}, 32'h9998);
        check_eq("down_wrap", {31'h0, i1.wrap}, 32'h0);

        // Clamp and priority with run=1 (every edge is a step cycle)
        i1.up = 1'b1;
        i1.load = 1'b1; i1.load_val = 16'hF3A1;
        edge1();
        check_eq("clamp_cnt", {16'h0, cnt1}, 32'h9391);
        check_eq("clamp_tick", {31'h0, i1.tick}, 32'h0);
        i1.clear = 1'b1;
        edge1();
        check_eq("clrld_cnt", {16'h0, cnt1}, 32'h0000);
        check_eq("clrld_tick", {31'h0, i1.tick}, 32'h0);
        i1.clear = 1'b0; i1.load_val = 16'h1234;
        edge1();
        check_eq("ld1_cnt", {16'h0, cnt1}, 32'h1234);
        edge1();
        check_eq("ld2_cnt", {16'h0, cnt1}, 32'h1234);
        check_eq("ld2_tick", {31'h0, i1.tick}, 32'h0);
        i1.load = 1'b0;
        edge1();
        check_eq("postld_cnt", {16'h0, cnt1}, 32'h1235);
        check_eq("postld_tick", {31'h0, i1.tick}, 32'h1);
        i1.up = 1'b0;
        edge1();
        check_eq("postld_dn", {16'h0, cnt1}, 32'h1234);
        i1.run = 1'b0;

        // Asynchronous reset mid-count, TICK_DIV=3
        i3.run = 1'b1; i3.up = 1'b1;
        repeat (126) edge1();
        check_eq("cnt3_42", {16'h0, cnt3}, 32'h0042);
        check_eq("cnt3_42_tick", {31'h0, i3.tick}, 32'h1);
        edge1();
        #1 rst3 = 1'b1;
        #1 check_eq("async_rst_cnt", {16'h0, cnt3}, 32'h0000);
        #1 rst3 = 1'b0;
        edge1();
        check_eq("post_rst_e1", {31'h0, i3.tick}, 32'h0);
        edge1();
        check_eq("post_rst_e2", {31'h0, i3.tick}, 32'h0);
        check_eq("post_rst_e2_cnt", {16'h0, cnt3}, 32'h0000);
        edge1();
        check_eq("post_rst_e3", {31'h0, i3.tick}, 32'h1);
        check_eq("post_rst_e3_cnt", {16'h0, cnt3}, 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
